// File: rtl/seq_alu_if.sv
// Operand/result handshake bundle between the decode/execute register, seq_alu and the memory stage.
interface seq_alu_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [3:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] C;
  logic             zero;
  logic             carry;
  logic             ovf;
  logic             dz;
  logic             illegal;

  modport master (
    output in_valid, A, B, op, out_ready,
    input  in_ready, out_valid, C, zero, carry, ovf, dz, illegal
  );

  modport slave (
    input  in_valid, A, B, op, out_ready,
    output in_ready, out_valid, C, zero, carry, ovf, dz, illegal
  );
endinterface

// File: rtl/seq_alu.sv
// Registered execute-stage ALU: 1-cycle ops plus radix-2 iterative multiply.
// Optional restoring divider for DIVU/REMU is enabled by defining ALU_DIV_EN.
module seq_alu #(
  parameter int unsigned WIDTH = 32
) (
  input logic      clk,
  input logic      rst,
  seq_alu_if.slave bus
);
  localparam int unsigned    SHW      = $clog2(WIDTH);
  localparam int unsigned    DW       = 2 * WIDTH;
  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  localparam logic [3:0] OP_ADD = 4'b0000, OP_SUB  = 4'b0001, OP_EQ   = 4'b0010, OP_GTU  = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0100, OP_OR   = 4'b0101, OP_XOR  = 4'b0110, OP_NOT  = 4'b0111;
  localparam logic [3:0] OP_SLT = 4'b1000, OP_SLL  = 4'b1001, OP_SRL  = 4'b1010, OP_SRA  = 4'b1011;
  localparam logic [3:0] OP_MUL = 4'b1100, OP_MULH = 4'b1101, OP_DIVU = 4'b1110, OP_REMU = 4'b1111;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e           state_q, state_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
  logic [DW-1:0]    acc_q, acc_d;
  logic             hi_q, hi_d;
  logic             zero_q, zero_d, carry_q, carry_d, ovf_q, ovf_d;
  logic             dz_q, dz_d, illegal_q, illegal_d;
  logic             in_ready_c;

  logic [WIDTH-1:0] res_c, mres_c;
  logic [WIDTH:0]   add_c, sub_c;
  logic [SHW-1:0]   sh_c;
  logic             carry_c, ovf_c, illegal_c, multi_c;
  logic [DW-1:0]    step_c;

`ifdef ALU_DIV_EN
  logic             div_q, div_d;
  logic [WIDTH:0]   rem_sh_c, rem_sub_c;
  logic             q_c;
`endif

  // Single-cycle datapath on the live operand ports
  always_comb begin
    add_c     = {1'b0, bus.A} + {1'b0, bus.B};
    sub_c     = {1'b0, bus.A} - {1'b0, bus.B};
    sh_c      = bus.B[SHW-1:0];
    res_c     = '0;
    carry_c   = 1'b0;
    ovf_c     = 1'b0;
    illegal_c = 1'b0;
    multi_c   = 1'b0;
    case (bus.op)
      OP_ADD: begin
        res_c   = add_c[WIDTH-1:0];
        carry_c = add_c[WIDTH];
        ovf_c   = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (add_c[WIDTH-1] != bus.A[WIDTH-1]);
      end
      OP_SUB: begin
        res_c   = sub_c[WIDTH-1:0];
        carry_c = sub_c[WIDTH];
        ovf_c   = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (sub_c[WIDTH-1] != bus.A[WIDTH-1]);
      end
      OP_EQ:   res_c = WIDTH'(bus.A == bus.B);
      OP_GTU:  res_c = WIDTH'(bus.A > bus.B);
      OP_AND:  res_c = bus.A & bus.B;
      OP_OR:   res_c = bus.A | bus.B;
      OP_XOR:  res_c = bus.A ^ bus.B;
      OP_NOT:  res_c = ~bus.A;
      OP_SLT:  res_c = WIDTH'($signed(bus.A) < $signed(bus.B));
      OP_SLL:  res_c = bus.A << sh_c;
      OP_SRL:  res_c = bus.A >> sh_c;
      OP_SRA:  res_c = $unsigned($signed(bus.A) >>> sh_c);
      OP_MUL, OP_MULH: multi_c = 1'b1;
`ifdef ALU_DIV_EN
      OP_DIVU, OP_REMU: multi_c = 1'b1;
`else
      OP_DIVU, OP_REMU: illegal_c = 1'b1;
`endif
      default: res_c = '0;
    endcase
  end

  // One radix-2 iteration: MSB-first shift-add multiply, or restoring divide step
  always_comb begin
    step_c = (acc_q << 1) + (b_q[WIDTH-1] ? {WIDTH'(0), a_q} : DW'(0));
`ifdef ALU_DIV_EN
    rem_sh_c  = {acc_q[DW-1:WIDTH], a_q[WIDTH-1]};
    rem_sub_c = rem_sh_c - {1'b0, b_q};
    q_c       = ~rem_sub_c[WIDTH];
    if (div_q) begin
      step_c = {(q_c ? rem_sub_c[WIDTH-1:0] : rem_sh_c[WIDTH-1:0]), acc_q[WIDTH-2:0], q_c};
    end
`endif
    mres_c = hi_q ? step_c[DW-1:WIDTH] : step_c[WIDTH-1:0];
  end

  // Next-state and handshake
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    a_d        = a_q;
    b_d        = b_q;
    acc_d      = acc_q;
    hi_d       = hi_q;
    c_d        = c_q;
    zero_d     = zero_q;
    carry_d    = carry_q;
    ovf_d      = ovf_q;
    dz_d       = dz_q;
    illegal_d  = illegal_q;
    in_ready_c = 1'b0;
`ifdef ALU_DIV_EN
    div_d      = div_q;
`endif
    case (state_q)
      IDLE: in_ready_c = 1'b1;
      DONE: begin
        in_ready_c = bus.out_ready;
        if (bus.out_ready) state_d = IDLE;
      end
      BUSY: begin
        cnt_d = cnt_q + SHW'(1);
        acc_d = step_c;
`ifdef ALU_DIV_EN
        if (div_q) a_d = a_q << 1;
        else       b_d = b_q << 1;
`else
        b_d = b_q << 1;
`endif
        if (cnt_q == CNT_LAST) begin
          c_d       = mres_c;
          zero_d    = (mres_c == '0);
          carry_d   = 1'b0;
          ovf_d     = 1'b0;
          illegal_d = 1'b0;
`ifdef ALU_DIV_EN
          dz_d      = div_q && (b_q == '0);
`else
          dz_d      = 1'b0;
`endif
          state_d   = DONE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (in_ready_c && bus.in_valid) begin
      if (multi_c) begin
        a_d     = bus.A;
        b_d     = bus.B;
        hi_d    = bus.op[0];
        acc_d   = '0;
        cnt_d   = '0;
`ifdef ALU_DIV_EN
        div_d   = bus.op[1];
`endif
        state_d = BUSY;
      end else begin
        c_d       = res_c;
        zero_d    = (res_c == '0);
        carry_d   = carry_c;
        ovf_d     = ovf_c;
        dz_d      = 1'b0;
        illegal_d = illegal_c;
        state_d   = DONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      hi_q      <= 1'b0;
      c_q       <= '0;
      zero_q    <= 1'b0;
      carry_q   <= 1'b0;
      ovf_q     <= 1'b0;
      dz_q      <= 1'b0;
      illegal_q <= 1'b0;
`ifdef ALU_DIV_EN
      div_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      hi_q      <= hi_d;
      c_q       <= c_d;
      zero_q    <= zero_d;
      carry_q   <= carry_d;
      ovf_q     <= ovf_d;
      dz_q      <= dz_d;
      illegal_q <= illegal_d;
`ifdef ALU_DIV_EN
      div_q     <= div_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = (state_q == DONE);
  assign bus.C         = c_q;
  assign bus.zero      = zero_q;
  assign bus.carry     = carry_q;
  assign bus.ovf       = ovf_q;
  assign bus.dz        = dz_q;
  assign bus.illegal   = illegal_q;
endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
Parametrised, registered successor to the execute-stage combinational ALU.
- Widens the op field to 4 bits and adds shifts, signed compare, and multi-cycle multiply (and optional divide).
- Adds status flags and a valid/ready handshake on both sides.
- Sits in the EXECUTE stage between the decode/execute register and the memory stage. It holds the upstream stage while a multi-cycle op runs.

Parameters:
- WIDTH, 32, operand and result width in bits (power of two, ≥8).
- SHW, $clog2(WIDTH), shift-amount bits taken from B[SHW-1:0] (derived, do not override).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands/op presented.
- in_ready  out  1  block accepts operands this cycle.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B.
- op  in  4  operation select.
- out_valid  out  1  result/flags valid.
- out_ready  in  1  downstream consumes result this cycle.
- C  out  WIDTH  result.
- zero  out  1  C == 0.
- carry  out  1  ADD carry-out; SUB borrow (A<B unsigned); else 0.
- ovf  out  1  signed overflow for ADD/SUB; else 0.
- dz  out  1  divide by zero (DIVU/REMU only).
- illegal  out  1  op not implemented in this build.

Behaviour:
- Interface decided: one clock, clk; reset rst is synchronous and active-high.
- Op encoding:
  - 0000 ADD, 0001 SUB, 0010 EQ (C=1 if A==B else 0), 0011 GTU (A>B unsigned).
  - 0100 AND, 0101 OR, 0110 XOR, 0111 NOT (~A).
  - 1000 SLT (signed A<B), 1001 SLL, 1010 SRL, 1011 SRA.
  - 1100 MUL (low WIDTH of unsigned product), 1101 MULHU (high WIDTH).
  - 1110 DIVU, 1111 REMU.
- Transfer occurs on in_valid & in_ready (accept) and on out_valid & out_ready (consume).
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - Accepting a 1-cycle op (0000–1011, or DIVU/REMU when divide is disabled): register result and flags, go to DONE. Latency 1: out_valid rises the cycle after accept.
  - Accepting MUL/MULHU (or DIVU/REMU when divide is enabled): latch A, B and op, clear the accumulator and the iteration counter, go to BUSY.
- BUSY:
  - in_ready=0.
  - One radix-2 iteration per cycle (shift-add multiply / restoring divide) over 2*WIDTH-bit state.
  - Counter runs 0..WIDTH-1; at WIDTH-1 write C and flags, go to DONE.
  - Total latency WIDTH+1 cycles from accept to out_valid.
- DONE:
  - out_valid=1; C and flags held stable until consumed.
  - in_ready = out_ready.
  - If consumed with no new accept, go to IDLE.
  - If consumed together with an accept, same cycle: handle as the IDLE accept (back-to-back 1-cycle ops sustain 1 result per cycle).
- Shifts use B[SHW-1:0] only; upper bits of B are ignored. SRA replicates A[WIDTH-1].
- ADD/SUB are computed at WIDTH+1 bits for carry. ovf = operand signs agree (ADD) or differ (SUB) and result sign differs from A.
- zero is computed on final C for every op; all other flags are 0 unless listed.
- Reset, including mid-BUSY:
  - Next edge: state=IDLE, out_valid=0, C=0, all flags 0, counter=0.
  - Any in-flight op is discarded with no result produced.
- Operand ports are don't-care when not accepting. Latched copies are used during BUSY.

Optional Feature:
Macro ALU_DIV_EN.
- Defined: DIVU/REMU run as a WIDTH-iteration restoring divider (latency WIDTH+1).
  - B==0: C = all ones for DIVU, C = A for REMU; dz=1; still takes full latency.
  - illegal=0.
- Undefined: divider logic is absent. DIVU/REMU complete as 1-cycle ops with C=0, illegal=1, dz=0.

Test Plan:
- Reset then ADD A=0xFFFFFFFF, B=1 → next cycle out_valid=1, C=0, zero=1, carry=1, ovf=0.
- SUB A=0x80000000, B=1 → C=0x7FFFFFFF, ovf=1, carry=0. SRA A=0x80000000, B=0x24 (shift 4) → C=0xF8000000.
- MUL A=0x0001_0000, B=0x0001_0000 → out_valid exactly 33 cycles after accept, C=0, zero=1, and in_ready=0 throughout BUSY. MULHU same operands → C=1.
- Back-to-back ADD,XOR,SLT with out_ready=1 → three results on consecutive cycles.
- Hold out_ready=0 for 5 cycles → C stable, in_ready=0.
- Assert rst at BUSY cycle 10 of MUL → out_valid stays 0, state IDLE, next op's result is correct.
- With ALU_DIV_EN: DIVU 100/7 → C=14; REMU 100/7 → C=2; DIVU 5/0 → C=0xFFFFFFFF, dz=1. Without ALU_DIV_EN: DIVU 100/7 → C=0, illegal=1 after 1 cycle.
